// File: rtl/tcb_lite_lib_dly.sv
// TCB-Lite response-delay converter: retimes a DLY_SUB subordinate response to DLY_MAN on the manager side.
// Optional macro TCB_LITE_LIB_DLY_HLD_EN: response stages load only on a transfer marker, so man_rsp holds.
module tcb_lite_lib_dly #(
  parameter  int unsigned DLY_MAN = 2,
  parameter  int unsigned DLY_SUB = 0,
  parameter  int unsigned CTL     = 1,
  parameter  int unsigned ADR     = 32,
  parameter  int unsigned DAT     = 32,
  parameter  int unsigned STS     = 1,
  localparam int unsigned BYT     = DAT / 8,
  localparam int unsigned SIZ     = $clog2($clog2(BYT) + 1),
  localparam int unsigned REQ     = 4 + CTL + ADR + SIZ + BYT + DAT,
  localparam int unsigned RSP     = DAT + STS + 1,
  localparam int unsigned CNW     = $clog2(DLY_MAN + 2)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           man_vld,
  output logic           man_rdy,
  input  logic [REQ-1:0] man_req,
  output logic [RSP-1:0] man_rsp,
  output logic           man_rsp_vld,
  output logic           sub_vld,
  input  logic           sub_rdy,
  output logic [REQ-1:0] sub_req,
  input  logic [RSP-1:0] sub_rsp,
  output logic [CNW-1:0] cnt
);

  localparam int unsigned DIF = (DLY_SUB > DLY_MAN) ? 0 : DLY_MAN - DLY_SUB;

  if (DLY_SUB > DLY_MAN) begin : g_err_dly
    $error("tcb_lite_lib_dly: DLY_SUB (%0d) exceeds DLY_MAN (%0d)", DLY_SUB, DLY_MAN);
  end
  if ((DAT < 8) || ((DAT & (DAT - 1)) != 0)) begin : g_err_dat
    $error("tcb_lite_lib_dly: DAT (%0d) must be a power of 2 and >= 8", DAT);
  end

  logic               trn;
  logic [DLY_MAN:0]   mrk;

  // request side is a pure pass-through
  assign sub_vld = man_vld;
  assign sub_req = man_req;
  assign man_rdy = sub_rdy;
  assign trn     = man_vld & sub_rdy;

  // transfer-marker delay line, mrk[k] flags a transfer made k cycles ago
  if (DLY_MAN > 0) begin : g_mrk
    logic [DLY_MAN:1] mrk_q;
    logic [DLY_MAN:1] mrk_d;

    always_comb begin
      mrk_d = mrk[DLY_MAN-1:0];
    end

    always_ff @(posedge clk) begin
      if (rst) mrk_q <= '0;
      else     mrk_q <= mrk_d;
    end

    assign mrk = {mrk_q, trn};
  end else begin : g_mrk_wire
    assign mrk = trn;
  end

  assign man_rsp_vld = mrk[DLY_MAN];

  // response pipe aligned with the markers from stage DLY_SUB onward
  if (DIF > 0) begin : g_rsp
    logic [DIF:1][RSP-1:0] rsp_q;
    logic [DIF:1][RSP-1:0] rsp_d;
    logic [DIF:0][RSP-1:0] rsp_in;

    assign rsp_in = {rsp_q, sub_rsp};

    always_comb begin
      rsp_d = rsp_q;
      for (int unsigned i = 1; i <= DIF; i++) begin
`ifdef TCB_LITE_LIB_DLY_HLD_EN
        if (mrk[DLY_SUB+i-1]) rsp_d[i] = rsp_in[i-1];
`else
        rsp_d[i] = rsp_in[i-1];
`endif
      end
    end

    always_ff @(posedge clk) begin
      if (rst) rsp_q <= '0;
      else     rsp_q <= rsp_d;
    end

    assign man_rsp = rsp_q[DIF];
  end else begin : g_rsp_wire
    assign man_rsp = sub_rsp;
  end

  // in-flight transfer counter
  logic [CNW-1:0] cnt_q;
  logic [CNW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    case ({trn, mrk[DLY_MAN]})
      2'b10:   cnt_d = cnt_q + CNW'(1);
      2'b01:   cnt_d = cnt_q - CNW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

  cnt_bound_a : assert property (@(posedge clk) disable iff (rst) cnt_q <= CNW'(DLY_MAN + 1));

endmodule
